// File: rtl/core_run_monitor.sv
// Run-control and trace monitor for the RISC-V cores: cycle/retire counters,
// halt/stall/timeout detection and a circular trace of data-memory writes.
module core_run_monitor #(
  parameter int                XLEN           = 32,
  parameter logic [XLEN-1:0]   HALT_PC        = 64,
  parameter int                TRACE_DEPTH    = 8,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter int                STALL_LIMIT    = 16,
  parameter int                CNT_W          = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [XLEN-1:0]                pc,
  input  logic [XLEN-1:0]                instr,
  input  logic                           retire,
  input  logic                           mem_write,
  input  logic [XLEN-1:0]                data_addr,
  input  logic [XLEN-1:0]                write_data,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               instr_count,
  output logic                           done,
  output logic [1:0]                     status,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [XLEN-1:0]                trace_rd_addr,
  output logic [XLEN-1:0]                trace_rd_data
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STALL_LIMIT) + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;
  logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     tcount_q, tcount_d;
  logic              trace_we;
  logic              pc_same;
  logic [AW-1:0]     rd_slot;

  logic [XLEN-1:0]   addr_mem [TRACE_DEPTH];
  logic [XLEN-1:0]   data_mem [TRACE_DEPTH];

  // The instruction word is sampled for port compatibility only; run control ignores it.
  logic unused_instr;
  assign unused_instr = ^instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      cycle_q    <= '0;
      instr_q    <= '0;
      done_q     <= 1'b0;
      status_q   <= 2'b00;
      prev_pc_q  <= '0;
      pc_valid_q <= 1'b0;
      stall_q    <= '0;
      wr_ptr_q   <= '0;
      tcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      done_q     <= done_d;
      status_q   <= status_d;
      prev_pc_q  <= prev_pc_d;
      pc_valid_q <= pc_valid_d;
      stall_q    <= stall_d;
      wr_ptr_q   <= wr_ptr_d;
      tcount_q   <= tcount_d;
    end
  end

  // pc_valid_q keeps the first sample after reset from counting as a repeat.
  assign pc_same = pc_valid_q && (pc == prev_pc_q);

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    instr_d    = instr_q;
    done_d     = done_q;
    status_d   = status_q;
    prev_pc_d  = prev_pc_q;
    pc_valid_d = pc_valid_q;
    stall_d    = stall_q;
    wr_ptr_d   = wr_ptr_q;
    tcount_d   = tcount_q;
    trace_we   = 1'b0;

    if (state_q != S_DONE) begin
      cycle_d    = cycle_q + CNT_W'(1);
      instr_d    = instr_q + CNT_W'(retire);
      prev_pc_d  = pc;
      pc_valid_d = 1'b1;
      stall_d    = pc_same ? stall_q + SW'(1) : '0;
      if (mem_write) begin
        trace_we = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (tcount_q < CW'(TRACE_DEPTH)) tcount_d = tcount_q + CW'(1);
      end
    end

    case (state_q)
      S_RUN: begin
        if (pc == HALT_PC) begin
          state_d  = S_DRAIN;
          status_d = 2'b01;
        end else if (pc_same && stall_q == SW'(STALL_LIMIT - 1)) begin
          state_d  = S_DONE;
          status_d = 2'b11;
          done_d   = 1'b1;
        end else if (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = S_DONE;
          status_d = 2'b10;
          done_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  // Trace storage has no reset; validity is tracked by tcount_q alone.
  always_ff @(posedge clk) begin
    if (trace_we) begin
      addr_mem[wr_ptr_q] <= data_addr;
      data_mem[wr_ptr_q] <= write_data;
    end
  end

  // Once full, the oldest entry sits at the write pointer.
  always_comb begin
    rd_slot       = (tcount_q == CW'(TRACE_DEPTH)) ? wr_ptr_q + trace_rd_idx : trace_rd_idx;
    trace_rd_addr = '0;
    trace_rd_data = '0;
    if ({1'b0, trace_rd_idx} < tcount_q) begin
      trace_rd_addr = addr_mem[rd_slot];
      trace_rd_data = data_mem[rd_slot];
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign done        = done_q;
  assign status      = status_q;
  assign trace_count = tcount_q;

endmodule

// File: tb/tb_core_run_monitor.sv
// Randomized/directed bench for core_run_monitor against a sample-history
// reference model (trace kept as a queue of the most recent writes).
module tb_core_run_monitor;
  localparam int TD   = 8;
  localparam int AW   = 3;
  localparam int TO   = 20;
  localparam int SL   = 16;
  localparam logic [31:0] HALT = 32'd64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, instr, data_addr, write_data;
  logic        retire, mem_write;
  logic [AW-1:0] trace_rd_idx;
  logic [31:0] cycle_count, instr_count;
  logic        done;
  logic [1:0]  status;
  logic [AW:0] trace_count;
  logic [31:0] trace_rd_addr, trace_rd_data;

  always #50 clk = ~clk;

  core_run_monitor #(
    .XLEN(32), .HALT_PC(HALT), .TRACE_DEPTH(TD),
    .TIMEOUT_CYCLES(TO), .STALL_LIMIT(SL), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .retire(retire),
    .mem_write(mem_write), .data_addr(data_addr), .write_data(write_data),
    .cycle_count(cycle_count), .instr_count(instr_count), .done(done),
    .status(status), .trace_count(trace_count), .trace_rd_idx(trace_rd_idx),
    .trace_rd_addr(trace_rd_addr), .trace_rd_data(trace_rd_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: totals, the length of the current run of identical PC
  // samples, and the last TD writes in arrival order.
  int unsigned m_cyc, m_ins;
  bit          m_done, m_drain, m_have_prev;
  logic [1:0]  m_status;
  logic [31:0] m_prev;
  int          m_run;
  logic [63:0] m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_ins = 0; m_done = 0; m_drain = 0; m_have_prev = 0;
    m_status = 2'b00; m_prev = '0; m_run = 0;
    m_q.delete();
  endtask

  task automatic model_step(input logic [31:0] p, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    if (m_done) return;
    m_cyc++;
    m_ins += r;
    if (w) begin
      m_q.push_back({a, d});
      if (m_q.size() > TD) void'(m_q.pop_front());
    end
    if (m_have_prev && p == m_prev) m_run++;
    else m_run = 1;
    m_prev = p;
    m_have_prev = 1;
    if (m_drain) begin
      m_drain = 0; m_done = 1;
    end else if (p == HALT) begin
      m_drain = 1; m_status = 2'b01;
    end else if (m_run == SL + 1) begin
      m_done = 1; m_status = 2'b11;
    end else if (m_cyc == TO) begin
      m_done = 1; m_status = 2'b10;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(m_cyc));
    chk({tag, "_instr_count"}, 64'(instr_count), 64'(m_ins));
    chk({tag, "_done"}, 64'(done), 64'(m_done));
    chk({tag, "_status"}, 64'(status), 64'(m_status));
    chk({tag, "_trace_count"}, 64'(trace_count), 64'(m_q.size()));
  endtask

  task automatic step(input logic [31:0] p, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    pc = p; retire = r; mem_write = w; data_addr = a; write_data = d;
    instr = $urandom;
    @(posedge clk);
    model_step(p, r, w, a, d);
    #1;
    check_outputs("step");
    $display("step pc=%h ret=%0d wr=%0d cyc=%0d ins=%0d done=%0d st=%0d tc=%0d",
             p, r, w, cycle_count, instr_count, done, status, trace_count);
  endtask

  task automatic rstep(input logic [31:0] p);
    step(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic check_trace(input string tag);
    logic [63:0] e;
    for (int i = 0; i < TD; i++) begin
      trace_rd_idx = AW'(i);
      #1;
      e = (i < m_q.size()) ? m_q[i] : 64'd0;
      chk({tag, "_trace_addr"}, 64'(trace_rd_addr), 64'(e[63:32]));
      chk({tag, "_trace_data"}, 64'(trace_rd_data), 64'(e[31:0]));
      $display("trace idx=%0d addr=%h data=%h", i, trace_rd_addr, trace_rd_data);
    end
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #20 reset = 1'b1;
    #1;
    chk({tag, "_rst_cycle"}, 64'(cycle_count), 64'd0);
    chk({tag, "_rst_instr"}, 64'(instr_count), 64'd0);
    chk({tag, "_rst_done"}, 64'(done), 64'd0);
    chk({tag, "_rst_status"}, 64'(status), 64'd0);
    chk({tag, "_rst_tcount"}, 64'(trace_count), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    $display("reset %s", tag);
  endtask

  task automatic run_halt(input string tag);
    for (int k = 0; k <= 16; k++) rstep(32'(4 * k)) ;
    chk({tag, "_done_at_halt"}, 64'(done), 64'd0);
    step(HALT, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    chk({tag, "_cycles"}, 64'(cycle_count), 64'd18);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_status"}, 64'(status), 64'd1);
  endtask

  initial begin
    logic [31:0] p;
    reset = 1'b1; pc = '0; instr = '0; retire = 0; mem_write = 0;
    data_addr = '0; write_data = '0; trace_rd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset_rd_addr", 64'(trace_rd_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Halt with retire held high; instr_count must track every cycle.
    for (int k = 0; k <= 16; k++) step(32'(4 * k), 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    chk("halt_done_early", 64'(done), 64'd0);
    step(HALT, 1'b1, 1'b0, '0, '0);
    chk("halt_cycles", 64'(cycle_count), 64'd18);
    chk("halt_instrs", 64'(instr_count), 64'd18);
    chk("halt_status", 64'(status), 64'd1);
    step(32'h10, 1'b1, 1'b1, 32'hdead, 32'hbeef);
    check_trace("halt");

    // Reset in DONE, then the same run again.
    async_reset("done");
    for (int k = 0; k <= 17; k++) step((k == 17) ? HALT : 32'(4 * k), 1'b1, 1'b0, '0, '0);
    chk("rerun_cycles", 64'(cycle_count), 64'd18);
    chk("rerun_instrs", 64'(instr_count), 64'd18);
    chk("rerun_status", 64'(status), 64'd1);

    // Timeout.
    async_reset("to");
    for (int k = 0; k < 30 && !m_done; k++) rstep(32'h200 + 32'(4 * k));
    chk("to_cycles", 64'(cycle_count), 64'd20);
    chk("to_status", 64'(status), 64'd2);
    check_trace("to");

    // Stall at 0x20.
    async_reset("stall");
    for (int k = 0; k < 30 && !m_done; k++) rstep(32'h20);
    chk("stall_status", 64'(status), 64'd3);
    chk("stall_done", 64'(done), 64'd1);

    // PC parked at the halt address: halt wins.
    async_reset("halt_hold");
    for (int k = 0; k < 4; k++) rstep(HALT);
    chk("hold_status", 64'(status), 64'd1);

    // Halt on the timeout cycle: halt wins.
    async_reset("collide");
    for (int k = 0; k < 19; k++) rstep(32'h400 + 32'(4 * k));
    rstep(HALT);
    chk("collide_status", 64'(status), 64'd1);
    rstep(HALT);
    chk("collide_cycles", 64'(cycle_count), 64'd21);

    // Trace wrap.
    async_reset("wrap");
    for (int k = 0; k < 10; k++) step(32'h300 + 32'(4 * k), 1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'(k));
    chk("wrap_tcount", 64'(trace_count), 64'd8);
    trace_rd_idx = 3'd0; #1;
    chk("wrap_idx0_addr", 64'(trace_rd_addr), 64'h108);
    chk("wrap_idx0_data", 64'(trace_rd_data), 64'd2);
    trace_rd_idx = 3'd7; #1;
    chk("wrap_idx7_addr", 64'(trace_rd_addr), 64'h124);
    chk("wrap_idx7_data", 64'(trace_rd_data), 64'd9);
    check_trace("wrap");

    // Out-of-range read and ignored write in DONE.
    async_reset("oor");
    for (int k = 0; k < 3; k++) step(32'h500 + 32'(4 * k), 1'b1, 1'b1, 32'h600 + 32'(k), 32'(k + 7));
    trace_rd_idx = 3'd5; #1;
    chk("oor_addr", 64'(trace_rd_addr), 64'd0);
    chk("oor_data", 64'(trace_rd_data), 64'd0);
    chk("oor_tcount", 64'(trace_count), 64'd3);
    step(HALT, 1'b1, 1'b0, '0, '0);
    step(HALT, 1'b1, 1'b0, '0, '0);
    step(32'h700, 1'b1, 1'b1, 32'h800, 32'h1);
    chk("oor_done_write", 64'(trace_count), 64'd3);
    check_trace("oor");

    // Random runs mixing repeats, jumps and halts.
    for (int r = 0; r < 5; r++) begin
      async_reset("rand");
      p = 32'h80;
      for (int k = 0; k < 30 && !m_done; k++) begin
        case ($urandom_range(0, 9))
          0:       p = (k > 5) ? HALT : p;
          1, 2, 3: p = p;
          default: p = p + 32'd4;
        endcase
        rstep(p);
      end
      chk("rand_done", 64'(done), 64'd1);
      check_trace("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
